// File: rtl/syscall_debug_port.sv
// Debug port that queues retired-syscall values and reports each one to an
// external monitor as a SETUP/HIGH/LOW handshake pulse on dbg_interrupt.
module syscall_debug_port #(
  parameter int DEPTH       = 4,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_valid,
  input  logic [31:0] syscall_value,
  output logic        dbg_interrupt,
  output logic [31:0] dbg_value,
  output logic [4:0]  pending_count,
  output logic        overflow,
  output logic [31:0] event_count
);

  localparam int              PW        = $clog2(DEPTH);
  localparam logic [4:0]      DEPTH_C   = 5'(DEPTH);
  localparam logic [15:0]     HIGH_LAST = 16'(HIGH_CYCLES - 1);
  localparam logic [15:0]     LOW_LAST  = 16'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [31:0]   value_q, value_d;
  logic [31:0]   events_q, events_d;
  logic          ovf_q, ovf_d;
  logic          irq_q;
  logic [31:0]   mem_q [DEPTH];

  logic full, pop, push;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign full = (count_q == DEPTH_C);
  assign pop  = (state_q == IDLE) && (count_q != 5'd0);
  assign push = syscall_valid && (!full || pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cyc_d    = cyc_q;
    value_d  = value_q;
    events_d = events_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (syscall_valid && full && !pop) ovf_d = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          value_d = mem_q[rd_ptr_q];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d  = HIGH;
        cyc_d    = 16'd0;
        events_d = events_q + 32'd1;
      end
      HIGH: begin
        if (cyc_q == HIGH_LAST) begin
          state_d = LOW;
          cyc_d   = 16'd0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      LOW: begin
        if (cyc_q == LOW_LAST) state_d = IDLE;
        else                   cyc_d   = cyc_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      value_q  <= '0;
      events_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      value_q  <= value_d;
      events_q <= events_d;
      ovf_q    <= ovf_d;
      irq_q    <= (state_d == HIGH);
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= syscall_value;
  end

  assign dbg_interrupt = irq_q;
  assign dbg_value     = value_q;
  assign pending_count = count_q;
  assign overflow      = ovf_q;
  assign event_count   = events_q;

endmodule

// File: tb/tb_syscall_debug_port.sv
// Directed self-checking bench for syscall_debug_port with a rising-edge
// monitor that records reported values, pulse start cycles and pulse widths.
module tb_syscall_debug_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_valid;
  logic [31:0] syscall_value;
  logic        dbg_interrupt;
  logic [31:0] dbg_value;
  logic [4:0]  pending_count;
  logic        overflow;
  logic [31:0] event_count;

  syscall_debug_port #(.DEPTH(4), .HIGH_CYCLES(2), .LOW_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .syscall_valid (syscall_valid),
    .syscall_value (syscall_value),
    .dbg_interrupt (dbg_interrupt),
    .dbg_value     (dbg_value),
    .pending_count (pending_count),
    .overflow      (overflow),
    .event_count   (event_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_rise = 0;
  logic [31:0] seen_q [$];
  int          rise_q [$];
  int          width_q[$];

  always @(posedge clk) cyc++;

  always @(posedge dbg_interrupt) begin
    seen_q.push_back(dbg_value);
    rise_q.push_back(cyc);
    last_rise = cyc;
  end

  always @(negedge dbg_interrupt) width_q.push_back(cyc - last_rise);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen_q.size()) ? seen_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int spacing_at(input int i);
    return (i + 1 < rise_q.size()) ? (rise_q[i+1] - rise_q[i]) : -1;
  endfunction

  task automatic clear_monitor();
    seen_q.delete();
    rise_q.delete();
    width_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    syscall_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_monitor();
  endtask

  task automatic push_one(input logic [31:0] v);
    syscall_valid = 1'b1;
    syscall_value = v;
    tick();
    syscall_valid = 1'b0;
  endtask

  logic [31:0] burst_v [4]  = '{20, 25, 30, 35};
  logic [4:0]  burst_p [4]  = '{1, 1, 2, 3};
  logic [31:0] seq_v   [12] = '{15, 20, 25, 30, 35, 40, 45, 9, 27, 3, 1, 0};
  logic [31:0] ovf_exp [5]  = '{100, 1, 2, 3, 4};

  initial begin
    reset = 1'b1;
    syscall_valid = 1'b0;
    syscall_value = '0;

    // Reset state, with a syscall strobe coinciding with reset that must be discarded.
    syscall_valid = 1'b1;
    syscall_value = 32'd99;
    tick();
    tick();
    syscall_valid = 1'b0;
    reset = 1'b0;
    check("rst_irq",      dbg_interrupt, 0);
    check("rst_value",    dbg_value,     0);
    check("rst_pending",  pending_count, 0);
    check("rst_overflow", overflow,      0);
    check("rst_events",   event_count,   0);
    repeat (4) tick();
    check("rst_no_pulse", seen_q.size(), 0);

    // Single event: written at E, popped at E+1, high after E+2 for two cycles.
    do_reset();
    push_one(32'd15);
    check("single_pend_E",   pending_count, 1);
    check("single_irq_E",    dbg_interrupt, 0);
    tick();
    check("single_pend_E1",  pending_count, 0);
    check("single_value_E1", dbg_value,     15);
    check("single_irq_E1",   dbg_interrupt, 0);
    tick();
    check("single_irq_E2",   dbg_interrupt, 1);
    check("single_events",   event_count,   1);
    tick();
    check("single_irq_E3",   dbg_interrupt, 1);
    tick();
    check("single_irq_E4",   dbg_interrupt, 0);
    check("single_value_E4", dbg_value,     15);
    repeat (4) tick();
    check("single_seen_n",   seen_q.size(), 1);
    check("single_seen_v",   seen_at(0),    15);
    check("single_width",    (width_q.size() > 0) ? width_q[0] : -1, 2);

    // Burst of four back-to-back strobes.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_one(burst_v[i]);
      check($sformatf("burst_pend_%0d", i), pending_count, burst_p[i]);
    end
    repeat (30) tick();
    check("burst_seen_n", seen_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("burst_v_%0d", i), seen_at(i), burst_v[i]);
    for (int i = 0; i < 3; i++) check($sformatf("burst_gap_%0d", i), spacing_at(i), 6);
    check("burst_overflow", overflow,    0);
    check("burst_events",   event_count, 4);

    // Overflow: 100 occupies the FSM, then 1..6 arrive back to back; 5 and 6 are dropped.
    do_reset();
    push_one(32'd100);
    for (int v = 1; v <= 6; v++) push_one(32'(v));
    check("ovf_flag",    overflow,      1);
    check("ovf_pending", pending_count, 4);
    repeat (40) tick();
    check("ovf_seen_n",  seen_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("ovf_v_%0d", i), seen_at(i), ovf_exp[i]);
    check("ovf_sticky",  overflow,      1);

    // Push on a full queue in the same cycle IDLE pops the head.
    do_reset();
    for (int v = 50; v <= 54; v++) push_one(32'(v));
    check("coll_full_pend", pending_count, 4);
    tick();
    tick();
    check("coll_pre_pend",  pending_count, 4);
    push_one(32'd55);
    check("coll_pend",      pending_count, 4);
    check("coll_overflow",  overflow,      0);
    check("coll_value",     dbg_value,     51);
    repeat (45) tick();
    check("coll_seen_n",    seen_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("coll_v_%0d", i), seen_at(i), 32'(50 + i));

    // Reset while HIGH with two events still queued.
    do_reset();
    push_one(32'd70);
    push_one(32'd71);
    push_one(32'd72);
    tick();
    check("midrst_in_high", dbg_interrupt, 1);
    check("midrst_pend",    pending_count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_irq",      dbg_interrupt, 0);
    check("midrst_value",    dbg_value,     0);
    check("midrst_pending",  pending_count, 0);
    check("midrst_overflow", overflow,      0);
    check("midrst_events",   event_count,   0);
    clear_monitor();
    repeat (20) tick();
    check("midrst_no_pulse", seen_q.size(), 0);

    // Twelve values at random gaps, each gap long enough that nothing is dropped.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(6, 12)) tick();
      push_one(seq_v[i]);
    end
    repeat (30) tick();
    check("seq_seen_n", seen_q.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("seq_v_%0d", i), seen_at(i), seq_v[i]);
    check("seq_events",   event_count, 12);
    check("seq_overflow", overflow,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
